// File: rtl/ecpeta_share_arb.sv
// Round-robin share of one external ECPETA adder between two requesters.
// Optional ECPETA_EXACT_CHECK_EN adds an exact-sum cross-check (out_err, err_cnt).
module ecpeta_share_arb #(
    parameter int N = 16
`ifdef ECPETA_EXACT_CHECK_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic [N-1:0]   adder_a,
    output logic [N-1:0]   adder_b,
    input  logic [N-1:0]   adder_sum,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_sum,
    output logic           out_tag
`ifdef ECPETA_EXACT_CHECK_EN
    ,
    output logic           out_err,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic         s1_valid;
    logic         s1_tag;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    logic         rr_ptr;
    logic         adv1;
    logic         adv2;
    logic [1:0]   grant;
    logic [1:0]   acc;
    logic         accept;
    logic         acc_idx;

    assign adv2 = !out_valid || out_ready;
    assign adv1 = !s1_valid || adv2;

    // Grant selection; with nobody asking, both are offered a slot
    always_comb begin
        grant = 2'b11;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b11;
        endcase
    end

    assign req_ready = grant & {2{adv1 && !rst}};
    assign acc       = req_valid & req_ready;
    assign accept    = |acc;
    assign acc_idx   = acc[1];

    assign adder_a = s1_a;
    assign adder_b = s1_b;

    // Stage 1: operand register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            rr_ptr   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag <= acc_idx;
                s1_a   <= acc_idx ? req_a[N +: N] : req_a[0 +: N];
                s1_b   <= acc_idx ? req_b[N +: N] : req_b[0 +: N];
                rr_ptr <= ~acc_idx;
            end
        end
    end

    // Stage 2: capture the adder result with its owner tag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_tag   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= adder_sum;
                out_tag <= s1_tag;
            end
        end
    end

`ifdef ECPETA_EXACT_CHECK_EN
    logic [N-1:0] exact;
    logic         mism;

    assign exact = adder_a + adder_b;
    assign mism  = adder_sum != exact;

    // Mismatch flag travels with out_sum; counter saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            out_err <= 1'b0;
            err_cnt <= '0;
        end else if (adv2 && s1_valid) begin
            out_err <= mism;
            if (mism && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ecpeta_share_arb.sv
// Bench for ecpeta_share_arb: behavioural ECPETA (k=4) as the shared adder,
// scoreboard queue filled on accept, drained by a negedge monitor.
module tb_ecpeta_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_tag;
`ifdef ECPETA_EXACT_CHECK_EN
    logic        out_err;
    logic [15:0] err_cnt;
`endif

    typedef struct {
        logic        tag;
        logic [15:0] sum;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   glog[$];
    exp_t mon_e;
    exp_t mon_n;
    int   errors = 0;
    int   checks = 0;
    int   nerr   = 0;
    int   npop   = 0;
    int   sent[2] = '{0, 0};
    int   lim[2]  = '{0, 0};
    int   ph      = 0;
    bit   auto_on = 1'b0;

    always #5 clk = ~clk;

    // ECPETA reference, k=4: low nibble OR, carry-in from bit 3 AND
    function automatic logic [15:0] ecpeta(input logic [15:0] a,
                                           input logic [15:0] b);
        logic [11:0] hi;
        hi = a[15:4] + b[15:4] + {11'b0, a[3] & b[3]};
        return {hi, a[3:0] | b[3:0]};
    endfunction

    assign adder_sum = ecpeta(adder_a, adder_b);

    ecpeta_share_arb dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .adder_a(adder_a),
        .adder_b(adder_b),
        .adder_sum(adder_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_tag(out_tag)
`ifdef ECPETA_EXACT_CHECK_EN
        ,
        .out_err(out_err),
        .err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] gen_a(input int i, input int k);
        return 16'(k * 16'h1357 + i * 16'h4321 + 16'h0808);
    endfunction

    function automatic logic [15:0] gen_b(input int i, input int k);
        return 16'(k * 16'h2468 + i * 16'h0F0F + 16'h0009);
    endfunction

    // Monitor: pop/compare on output transfer, push on accept
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            nerr = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got tag %0d sum %h required none",
                             out_tag, out_sum);
                end else begin
                    mon_e = q.pop_front();
                    npop++;
                    if (mon_e.err) nerr++;
                    chk("sb_tag", 32'(out_tag), 32'(mon_e.tag));
                    chk("sb_sum", 32'(out_sum), 32'(mon_e.sum));
                    chk("sb_x", 32'($isunknown(out_sum)), 32'd0);
`ifdef ECPETA_EXACT_CHECK_EN
                    chk("sb_err", 32'(out_err), 32'(mon_e.err));
`endif
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_n.tag = 1'(i);
                    mon_n.sum = ecpeta(req_a[i*16 +: 16], req_b[i*16 +: 16]);
                    mon_n.err = mon_n.sum !=
                                16'(req_a[i*16 +: 16] + req_b[i*16 +: 16]);
                    q.push_back(mon_n);
                    glog.push_back(i);
                    sent[i]++;
                end
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]       = (sent[i] < lim[i]);
            req_a[i*16 +: 16]  = gen_a(i, sent[i] + ph);
            req_b[i*16 +: 16]  = gen_b(i, sent[i] + ph);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_on) apply();
    endtask

    task automatic start_stream(input int n, input int phase);
        ph      = phase;
        lim[0]  = sent[0] + n;
        lim[1]  = sent[1] + n;
        auto_on = 1'b1;
        apply();
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (q.size() == 0 && sent[0] >= lim[0] && sent[1] >= lim[1])
                done = 1'b1;
            else
                step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got %0d pending required 0", name, q.size());
        end
        auto_on   = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        int base;
        int vcnt;
        int p0;
        logic [15:0] s0;
        logic        t0;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_adder_a", 32'(adder_a), 32'd0);
        chk("rst_adder_b", 32'(adder_b), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ECPETA_EXACT_CHECK_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'h3);

        // Single request, 2-cycle latency
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        req_a     = {16'h0000, 16'h1234};
        req_b     = {16'h0000, 16'h5678};
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_tag", 32'(out_tag), 32'd0);
        chk("single_sum", 32'(out_sum), 32'h68AC);

        // Reset so the pointer starts at requester 0
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention: alternating grants, one result per cycle
        base = glog.size();
        start_stream(3, 0);
        step();
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("contend_thru", 32'(vcnt), 32'd6);
        drain("contend_drain");
        chk("contend_ngrant", 32'(glog.size() - base), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < glog.size())
                chk("contend_order", 32'(glog[base + k]), 32'(k % 2));
        end

        // Backpressure with both requesters streaming
        p0 = npop;
        start_stream(3, 7);
        step();
        step();
        out_ready = 1'b0;
        @(negedge clk);
        s0 = out_sum;
        t0 = out_tag;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk("bp_sum_hold", 32'(out_sum), 32'(s0));
            chk("bp_tag_hold", 32'(out_tag), 32'(t0));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        step();
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_count", 32'(npop - p0), 32'd6);

        // Wrap-around operands on requester 1
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        req_a     = {16'hFFFF, 16'h0000};
        req_b     = {16'h0001, 16'h0000};
        @(posedge clk);
        #1;
        req_a = {16'hAAAA, 16'h0000};
        req_b = {16'h5555, 16'h0000};
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("wrap1_sum", 32'(out_sum), 32'hFFFF);
        chk("wrap1_tag", 32'(out_tag), 32'd1);
`ifdef ECPETA_EXACT_CHECK_EN
        chk("wrap1_err", 32'(out_err), 32'd1);
`endif
        @(negedge clk);
        chk("wrap2_sum", 32'(out_sum), 32'hFFFF);
        chk("wrap2_valid", 32'(out_valid), 32'd1);
`ifdef ECPETA_EXACT_CHECK_EN
        chk("wrap2_err", 32'(out_err), 32'd0);
`endif
        drain("wrap_drain");

        // Reset with two results in flight
        start_stream(2, 20);
        step();
        step();
        rst       = 1'b1;
        auto_on   = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lim[0] = sent[0];
        lim[1] = sent[1];
        @(negedge clk);
        chk("rst_flush", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
`ifdef ECPETA_EXACT_CHECK_EN
        chk("rst_err_clr", 32'(err_cnt), 32'd0);
`endif

        // Pointer back at 0; one approximate and one exact vector
        @(posedge clk);
        #1;
        base      = glog.size();
        req_valid = 2'b11;
        req_a     = {16'hAAAA, 16'hFFFF};
        req_b     = {16'h5555, 16'h0001};
        @(negedge clk);
        chk("rr_after_rst", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("final_drain");
        if (glog.size() > base)
            chk("rr_first", 32'(glog[base]), 32'd0);
`ifdef ECPETA_EXACT_CHECK_EN
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("err_cnt", 32'(err_cnt), 32'(nerr));
        chk("err_cnt_val", 32'(err_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
